// File: rtl/bip_pkg.sv
// Shared definitions for the BIP-I handshake core: opcode values, FSM states, ALU operations.
package bip_pkg;

    localparam int unsigned OP_HLT  = 0;
    localparam int unsigned OP_STO  = 1;
    localparam int unsigned OP_LD   = 2;
    localparam int unsigned OP_LDI  = 3;
    localparam int unsigned OP_ADD  = 4;
    localparam int unsigned OP_ADDI = 5;
    localparam int unsigned OP_SUB  = 6;
    localparam int unsigned OP_SUBI = 7;
    localparam int unsigned OP_BEQ  = 8;
    localparam int unsigned OP_BNE  = 9;
    localparam int unsigned OP_JMP  = 10;

    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_e;

    typedef enum logic [1:0] {ALU_PASS, ALU_ADD, ALU_SUB} alu_op_e;

    // Replicates bit w-1 of v into all higher bits (1 <= w <= 64).
    function automatic logic [63:0] sign_ext(input logic [63:0] v, input int unsigned w);
        logic signed [63:0] t;
        t = $signed(v << (64 - w));
        return t >>> (64 - w);
    endfunction

endpackage

// File: rtl/bip_alu.sv
// Combinational accumulator ALU: pass operand, add or subtract, modulo 2^DATA_W.
module bip_alu
    import bip_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = b_i;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            default: y_o = b_i;
        endcase
    end

endmodule

// File: rtl/bip_cpu_hs.sv
// Parametrised BIP-I accumulator core with valid/ack handshakes on program and data memory.
// Optional BEQ/BNE/JMP support is enabled by defining BIP_BRANCH_EN.
module bip_cpu_hs
    import bip_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned OPC_W  = 5
) (
    input  logic                    CLK,
    input  logic                    RESET,
    output logic                    PM_RD,
    output logic [ADDR_W-1:0]       PM_ADDR,
    input  logic [OPC_W+ADDR_W-1:0] PM_DATA,
    input  logic                    PM_VALID,
    output logic                    DM_RD,
    output logic                    DM_WR,
    output logic [ADDR_W-1:0]       DM_ADDR,
    output logic [DATA_W-1:0]       DM_WDATA,
    input  logic [DATA_W-1:0]       DM_RDATA,
    input  logic                    DM_ACK,
    output logic [DATA_W-1:0]       ACC,
    output logic [ADDR_W-1:0]       PC,
    output logic                    HALTED
);

    localparam int unsigned INSTR_W = OPC_W + ADDR_W;

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_exec_d;
    logic [DATA_W-1:0]  acc_q;
    logic [INSTR_W-1:0] ir_q;
    logic               pm_rd_q;
    logic               dm_rd_q;
    logic               dm_wr_q;
    logic               halted_q;

    logic [31:0]        opc;
    logic [ADDR_W-1:0]  operand;
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W-1:0]  alu_b;
    logic [DATA_W-1:0]  alu_y;
    alu_op_e            alu_op;

    assign opc     = 32'(ir_q[INSTR_W-1:ADDR_W]);
    assign operand = ir_q[ADDR_W-1:0];
    assign imm_ext = DATA_W'(sign_ext(64'(operand), ADDR_W));
    assign alu_b   = (state_q == ST_MEM) ? DM_RDATA : imm_ext;

    always_comb begin
        alu_op = ALU_PASS;
        case (opc)
            OP_ADD, OP_ADDI: alu_op = ALU_ADD;
            OP_SUB, OP_SUBI: alu_op = ALU_SUB;
            default:         alu_op = ALU_PASS;
        endcase
    end

    always_comb begin
        pc_exec_d = pc_q + ADDR_W'(1);
`ifdef BIP_BRANCH_EN
        case (opc)
            OP_BEQ:  if (acc_q == '0) pc_exec_d = operand;
            OP_BNE:  if (acc_q != '0) pc_exec_d = operand;
            OP_JMP:  pc_exec_d = operand;
            default: ;
        endcase
`endif
    end

    bip_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i (alu_op),
        .a_i  (acc_q),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            acc_q    <= '0;
            ir_q     <= '0;
            pm_rd_q  <= 1'b0;
            dm_rd_q  <= 1'b0;
            dm_wr_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                // PM_RD comes out of reset low, so the first fetch raises it before accepting data.
                ST_FETCH: begin
                    pm_rd_q <= 1'b1;
                    if (pm_rd_q && PM_VALID) begin
                        ir_q    <= PM_DATA;
                        pm_rd_q <= 1'b0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (opc)
                        OP_HLT: begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end
                        OP_STO: begin
                            dm_wr_q <= 1'b1;
                            state_q <= ST_MEM;
                        end
                        OP_LD, OP_ADD, OP_SUB: begin
                            dm_rd_q <= 1'b1;
                            state_q <= ST_MEM;
                        end
                        OP_LDI, OP_ADDI, OP_SUBI: begin
                            acc_q   <= alu_y;
                            pc_q    <= pc_exec_d;
                            pm_rd_q <= 1'b1;
                            state_q <= ST_FETCH;
                        end
                        default: begin
                            pc_q    <= pc_exec_d;
                            pm_rd_q <= 1'b1;
                            state_q <= ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (DM_ACK) begin
                        if (dm_rd_q) acc_q <= alu_y;
                        dm_rd_q <= 1'b0;
                        dm_wr_q <= 1'b0;
                        pc_q    <= pc_q + ADDR_W'(1);
                        pm_rd_q <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_HALT: ;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign PM_RD    = pm_rd_q;
    assign PM_ADDR  = pc_q;
    assign DM_RD    = dm_rd_q;
    assign DM_WR    = dm_wr_q;
    assign DM_ADDR  = operand;
    assign DM_WDATA = acc_q;
    assign ACC      = acc_q;
    assign PC       = pc_q;
    assign HALTED   = halted_q;

endmodule

// File: tb/tb_bip_cpu_hs.sv
// Self-checking bench for bip_cpu_hs: instruction-level model plus directed programs.
`timescale 1ns/1ps
module tb_bip_cpu_hs;

    localparam int unsigned AW = 11;
    localparam int unsigned IW = 16;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic          pm_rd, pm_valid, dm_rd, dm_wr, dm_ack, halted;
    logic [AW-1:0] pm_addr, dm_addr, pc;
    logic [IW-1:0] pm_data;
    logic [15:0]   dm_wdata, dm_rdata, acc;

    logic          pm_rd24, pm_valid24, dm_rd24, dm_wr24, dm_ack24, halted24;
    logic [AW-1:0] pm_addr24, dm_addr24, pc24;
    logic [IW-1:0] pm_data24;
    logic [23:0]   dm_wdata24, dm_rdata24, acc24;

    logic [IW-1:0] pm      [2048];
    logic [15:0]   dm      [2048];
    logic [15:0]   dm_init [2048];
    int unsigned   dm_wait;
    int unsigned   dm_cnt;
    logic [AW-1:0] last_wr_addr;
    logic [15:0]   last_wr_data;

    int n_vec = 0;
    int n_bad = 0;

    bip_cpu_hs #(.DATA_W(16), .ADDR_W(AW), .OPC_W(5)) u_dut (
        .CLK(CLK), .RESET(RESET),
        .PM_RD(pm_rd), .PM_ADDR(pm_addr), .PM_DATA(pm_data), .PM_VALID(pm_valid),
        .DM_RD(dm_rd), .DM_WR(dm_wr), .DM_ADDR(dm_addr), .DM_WDATA(dm_wdata),
        .DM_RDATA(dm_rdata), .DM_ACK(dm_ack),
        .ACC(acc), .PC(pc), .HALTED(halted)
    );

    bip_cpu_hs #(.DATA_W(24), .ADDR_W(AW), .OPC_W(5)) u_dut24 (
        .CLK(CLK), .RESET(RESET),
        .PM_RD(pm_rd24), .PM_ADDR(pm_addr24), .PM_DATA(pm_data24), .PM_VALID(pm_valid24),
        .DM_RD(dm_rd24), .DM_WR(dm_wr24), .DM_ADDR(dm_addr24), .DM_WDATA(dm_wdata24),
        .DM_RDATA(dm_rdata24), .DM_ACK(dm_ack24),
        .ACC(acc24), .PC(pc24), .HALTED(halted24)
    );

    // Zero-wait program memories; data memory acks after dm_wait idle cycles.
    assign pm_valid   = pm_rd;
    assign pm_data    = pm[pm_addr];
    assign pm_valid24 = pm_rd24;
    assign pm_data24  = pm[pm_addr24];
    assign dm_ack24   = dm_rd24 | dm_wr24;
    assign dm_rdata24 = '0;
    assign dm_ack     = (dm_rd || dm_wr) && (dm_cnt == dm_wait);
    assign dm_rdata   = dm[dm_addr];

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 2048; i++) dm[i] <= dm_init[i];
            dm_cnt <= 0;
        end else if (dm_rd || dm_wr) begin
            if (dm_ack) begin
                dm_cnt <= 0;
                if (dm_wr) begin
                    dm[dm_addr]  <= dm_wdata;
                    last_wr_addr <= dm_addr;
                    last_wr_data <= dm_wdata;
                end
            end else begin
                dm_cnt <= dm_cnt + 1;
            end
        end else begin
            dm_cnt <= 0;
        end
    end

    // Architectural model state (one instruction per accepted fetch).
    logic [AW-1:0] m_pc;
    logic [15:0]   m_acc;
    logic          m_halted;
    logic [15:0]   mdm [2048];
    logic          m_pend, m_pend_wr;
    logic [AW-1:0] m_pend_addr;
    logic [15:0]   m_pend_data;
    int            m_lat, cyc, last_fetch;
    logic          have_last;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    function automatic logic [15:0] ins(input int op, input int opd);
        logic [31:0] o, d;
        o = op;
        d = opd;
        return {o[4:0], d[10:0]};
    endfunction

    task automatic model_step();
        logic [15:0]   w, imm, mv;
        logic [4:0]    op;
        logic [AW-1:0] opd;
        w   = pm[m_pc];
        op  = w[15:11];
        opd = w[10:0];
        imm = 16'($signed(opd));
        mv  = mdm[opd];
        m_lat = 2;
        case (op)
            5'd0: m_halted = 1'b1;
            5'd1: begin
                m_pend = 1'b1; m_pend_wr = 1'b1; m_pend_addr = opd; m_pend_data = m_acc;
                mdm[opd] = m_acc; m_lat = 3 + int'(dm_wait); m_pc = m_pc + 11'd1;
            end
            5'd2, 5'd4, 5'd6: begin
                m_pend = 1'b1; m_pend_wr = 1'b0; m_pend_addr = opd;
                if (op == 5'd2) m_acc = mv;
                else if (op == 5'd4) m_acc = m_acc + mv;
                else m_acc = m_acc - mv;
                m_lat = 3 + int'(dm_wait); m_pc = m_pc + 11'd1;
            end
            5'd3: begin m_acc = imm;         m_pc = m_pc + 11'd1; end
            5'd5: begin m_acc = m_acc + imm; m_pc = m_pc + 11'd1; end
            5'd7: begin m_acc = m_acc - imm; m_pc = m_pc + 11'd1; end
`ifdef BIP_BRANCH_EN
            5'd8:  m_pc = (m_acc == 16'd0) ? opd : m_pc + 11'd1;
            5'd9:  m_pc = (m_acc != 16'd0) ? opd : m_pc + 11'd1;
            5'd10: m_pc = opd;
`endif
            default: m_pc = m_pc + 11'd1;
        endcase
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    task automatic model_cycle();
        if (RESET) begin
            m_pc = '0; m_acc = '0; m_halted = 1'b0; m_pend = 1'b0; m_pend_wr = 1'b0;
            have_last = 1'b0; cyc = 0; last_fetch = 0; m_lat = 2;
            for (int i = 0; i < 2048; i++) mdm[i] = dm_init[i];
            return;
        end
        cyc++;
        chk("rd_wr_exclusive", 64'(dm_rd && dm_wr), 64'(0));
        if (pm_rd && pm_valid) begin
            chk("fetch_addr", 64'(pm_addr), 64'(m_pc));
            chk("fetch_acc", 64'(acc), 64'(m_acc));
            if (have_last) chk("instr_latency", 64'(cyc - last_fetch), 64'(m_lat));
            have_last  = 1'b1;
            last_fetch = cyc;
            model_step();
        end
        if (dm_ack) begin
            chk("dm_access_expected", 64'(1), 64'(m_pend));
            chk("dm_direction", 64'(dm_wr), 64'(m_pend_wr));
            chk("dm_addr", 64'(dm_addr), 64'(m_pend_addr));
            if (m_pend_wr) chk("dm_wdata", 64'(dm_wdata), 64'(m_pend_data));
            m_pend = 1'b0;
        end
        if (halted) begin
            chk("halt_expected", 64'(m_halted), 64'(1));
            chk("halt_pc", 64'(pc), 64'(m_pc));
            chk("halt_acc", 64'(acc), 64'(m_acc));
            chk("halt_no_fetch", 64'(pm_rd), 64'(0));
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        model_cycle();
    endtask

    task automatic clear_mem(input logic [15:0] fill);
        for (int i = 0; i < 2048; i++) begin
            pm[i]      = fill;
            dm_init[i] = '0;
        end
    endtask

    task automatic start();
        RESET = 1'b0;
    endtask

    task automatic hold_reset();
        RESET = 1'b1;
        tick();
        tick();
    endtask

    task automatic wait_halt(input string nm, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        if (!halted) timeout(nm);
    endtask

    task automatic next_fetch(input string nm, output logic [AW-1:0] a);
        int n;
        n = 0;
        tick();
        while (!pm_rd && n < 200) begin
            tick();
            n++;
        end
        if (!pm_rd) timeout(nm);
        a = pm_addr;
    endtask

    initial begin
        logic [AW-1:0] a;
        int cnt, n, k;
        logic stable;

        RESET   = 1'b1;
        dm_wait = 0;
        clear_mem(16'h0000);
        tick();
        chk("rst_pm_rd", 64'(pm_rd), 64'(0));
        chk("rst_dm_rd", 64'(dm_rd), 64'(0));
        chk("rst_dm_wr", 64'(dm_wr), 64'(0));
        chk("rst_pc", 64'(pc), 64'(0));
        chk("rst_acc", 64'(acc), 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));

        // LDI 5; ADDI -2; STO 10; HLT
        pm[0] = ins(3, 5); pm[1] = ins(5, 11'h7FE); pm[2] = ins(1, 10); pm[3] = ins(0, 0);
        hold_reset();
        start();
        wait_halt("t1_halt", 100);
        chk("t1_wr_addr", 64'(last_wr_addr), 64'd10);
        chk("t1_wr_data", 64'(last_wr_data), 64'd3);
        chk("t1_pc", 64'(pc), 64'd3);
        chk("t1_halted", 64'(halted), 64'd1);

        // LD 7 with four wait cycles on the data memory
        RESET = 1'b1;
        clear_mem(16'h0000);
        dm_init[7] = 16'h1234;
        dm_wait = 4;
        pm[0] = ins(2, 7); pm[1] = ins(0, 0);
        hold_reset();
        start();
        n = 0;
        while (!dm_rd && n < 50) begin tick(); n++; end
        cnt = 0;
        stable = 1'b1;
        while (dm_rd && n < 100) begin
            cnt++;
            if (dm_addr !== 11'd7) stable = 1'b0;
            tick();
            n++;
        end
        chk("t2_rd_cycles", 64'(cnt), 64'd5);
        chk("t2_addr_stable", 64'(stable), 64'd1);
        wait_halt("t2_halt", 100);
        chk("t2_acc", 64'(acc), 64'h1234);

        // LDI 1; SUBI 2 on both widths
        RESET = 1'b1;
        clear_mem(16'h0000);
        dm_wait = 0;
        pm[0] = ins(3, 1); pm[1] = ins(7, 2); pm[2] = ins(0, 0);
        hold_reset();
        start();
        wait_halt("t3_halt", 100);
        chk("t3_acc16", 64'(acc), 64'hFFFF);
        chk("t3_halted24", 64'(halted24), 64'd1);
        chk("t3_acc24", 64'(acc24), 64'hFF_FFFF);

        // Memory arithmetic with two wait cycles
        RESET = 1'b1;
        clear_mem(16'h0000);
        dm_init[7] = 16'h1234;
        dm_init[8] = 16'h0034;
        dm_wait = 2;
        pm[0] = ins(3, 100); pm[1] = ins(4, 7); pm[2] = ins(6, 8);
        pm[3] = ins(1, 9);   pm[4] = ins(2, 9); pm[5] = ins(0, 0);
        hold_reset();
        start();
        wait_halt("t7_halt", 200);
        chk("t7_acc", 64'(acc), 64'h1264);
        chk("t7_wr_addr", 64'(last_wr_addr), 64'd9);
        chk("t7_wr_data", 64'(last_wr_data), 64'h1264);

        // All-NOP program: PC wraps from 2047 to 0
        RESET = 1'b1;
        clear_mem(ins(31, 0));
        dm_wait = 0;
        hold_reset();
        start();
        k = 0;
        a = '0;
        do begin
            next_fetch("t4_fetch", a);
            k++;
        end while (a != 11'd2047 && k < 3000);
        if (a != 11'd2047) timeout("t4_reach_2047");
        next_fetch("t4_wrap_fetch", a);
        chk("t4_pc_wrap", 64'(a), 64'd0);

        // Reset while a store is waiting for its ack
        RESET = 1'b1;
        clear_mem(16'h0000);
        dm_wait = 20;
        pm[0] = ins(3, 9); pm[1] = ins(1, 5); pm[2] = ins(0, 0);
        hold_reset();
        start();
        n = 0;
        while (!dm_wr && n < 50) begin tick(); n++; end
        if (!dm_wr) timeout("t5_wait_wr");
        #2 RESET = 1'b1;
        #1;
        chk("t5_dm_wr_cleared", 64'(dm_wr), 64'd0);
        chk("t5_pc_cleared", 64'(pc), 64'd0);
        chk("t5_acc_cleared", 64'(acc), 64'd0);
        chk("t5_pm_rd_cleared", 64'(pm_rd), 64'd0);
        tick();
        @(posedge CLK);
        #1 RESET = 1'b0;
        next_fetch("t5_refetch", a);
        chk("t5_restart_addr", 64'(a), 64'd0);
        wait_halt("t5_halt", 200);
        chk("t5_wr_data", 64'(last_wr_data), 64'd9);

        // LDI 0; BEQ 20; then JMP 30; BNE 40 (not taken); HLT at 31
        RESET = 1'b1;
        clear_mem(16'h0000);
        dm_wait = 0;
        pm[0] = ins(3, 0); pm[1] = ins(8, 20); pm[2] = ins(0, 0);
        pm[20] = ins(10, 30); pm[30] = ins(9, 40); pm[31] = ins(0, 0);
        hold_reset();
        start();
        next_fetch("t6_f0", a);
        next_fetch("t6_f1", a);
        next_fetch("t6_f2", a);
`ifdef BIP_BRANCH_EN
        chk("t6_beq_target", 64'(a), 64'd20);
        wait_halt("t6_halt", 100);
        chk("t6_final_pc", 64'(pc), 64'd31);
`else
        chk("t6_beq_nop", 64'(a), 64'd2);
        wait_halt("t6_halt", 100);
        chk("t6_final_pc", 64'(pc), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
